// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter: read-return owner
// encodings, default starvation limit and the grant priority function.
package dm_port_arbiter_pkg;

   // Owner of the read data returning from the RAM in the current cycle
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_MEM = 2'd1,
      RD_DBG = 2'd2
   } rd_owner_e;

   localparam int STARVE_LIMIT_DEF = 8;
   localparam int CNT_W_DEF        = 4;

   typedef struct packed {
      logic mem;
      logic dbg;
   } grant_t;

   // MEM has fixed priority; dbg wins when MEM is idle or dbg has starved.
   // 'en' kills both grants, which keeps the RAM quiet while in reset.
   function automatic grant_t arb_grant(
      input logic en,
      input logic mem_req,
      input logic dbg_req,
      input logic starve_hit
   );
      grant_t g;
      g.dbg = en & dbg_req & (~mem_req | starve_hit);
      g.mem = en & mem_req & ~g.dbg;
      return g;
   endfunction

endpackage

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single synchronous-read data RAM port between the MEM stage
// (priority) and the debug requester. Grants are combinational; read data is
// routed back one cycle later to whichever requester issued the read.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   input  logic [3:0]  dbg_wen,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_wen,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   rd_owner_e        r_rd_owner;
   rd_owner_e        w_rd_owner_nxt;
   logic [CNT_W-1:0] r_starve_cnt;
   logic [CNT_W-1:0] w_starve_cnt_nxt;
   logic             w_starve_hit;
   grant_t           w_gnt;

   assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   // resetn gates the grant so nothing (in particular no write) reaches the RAM in reset
   assign w_gnt        = arb_grant(resetn, mem_req, dbg_req, w_starve_hit);

   // State register: read-return owner and dbg starvation counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_owner   <= IDLE;
         r_starve_cnt <= {CNT_W{1'b0}};
      end else begin
         r_rd_owner   <= w_rd_owner_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end

   // Next state: owner follows this cycle's grant, counter tracks denied dbg cycles
   always_comb begin
      w_rd_owner_nxt   = IDLE;
      w_starve_cnt_nxt = r_starve_cnt;

      if (w_gnt.mem) begin
         if (mem_wen == 4'b0000) begin
            w_rd_owner_nxt = RD_MEM;
         end else begin
            w_rd_owner_nxt = IDLE;
         end
      end else if (w_gnt.dbg) begin
         if (dbg_wen == 4'b0000) begin
            w_rd_owner_nxt = RD_DBG;
         end else begin
            w_rd_owner_nxt = IDLE;
         end
      end else begin
         w_rd_owner_nxt = IDLE;
      end

      if (!dbg_req || w_gnt.dbg) begin
         w_starve_cnt_nxt = {CNT_W{1'b0}};
      end else if (!w_starve_hit) begin
         w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
      end else begin
         w_starve_cnt_nxt = r_starve_cnt;
      end
   end

   // Outputs: grants, RAM steering and read-return valids
   always_comb begin
      mem_gnt    = w_gnt.mem;
      dbg_gnt    = w_gnt.dbg;
      ram_addr   = mem_addr;
      ram_wdata  = mem_wdata;
      ram_wen    = 4'b0000;
      mem_rvalid = 1'b0;
      dbg_rvalid = 1'b0;
      mem_rdata  = ram_rdata;
      dbg_rdata  = ram_rdata;

      if (w_gnt.mem) begin
         ram_addr  = mem_addr;
         ram_wdata = mem_wdata;
         ram_wen   = mem_wen;
      end else if (w_gnt.dbg) begin
         ram_addr  = dbg_addr;
         ram_wdata = dbg_wdata;
         ram_wen   = dbg_wen;
      end else begin
         ram_addr  = mem_addr;
         ram_wdata = mem_wdata;
         ram_wen   = 4'b0000;
      end

      case (r_rd_owner)
         RD_MEM:  mem_rvalid = 1'b1;
         RD_DBG:  dbg_rvalid = 1'b1;
         IDLE:    mem_rvalid = 1'b0;
         default: begin
            mem_rvalid = 1'b0;
            dbg_rvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small synchronous-read RAM model.
module tb_dm_port_arbiter;

   logic        clk;
   logic        resetn;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic [3:0]  dbg_wen;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [31:0] ram_addr;
   logic [3:0]  ram_wen;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] ram_mem [0:63];

   int n_checks;
   int n_errors;

   dm_port_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) u_dut (
      .clk        (clk),
      .resetn     (resetn),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_wen    (dbg_wen),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .ram_addr   (ram_addr),
      .ram_wen    (ram_wen),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: byte-enabled write, read data registered (old data on same-cycle write)
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (ram_wen[k]) ram_mem[ram_addr[7:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
      end
      ram_rdata <= ram_mem[ram_addr[7:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of requests at the falling edge, settle, then return for checks
   task automatic drive(input logic mr, input logic [31:0] ma, input logic [3:0] mw,
                        input logic [31:0] md, input logic dr, input logic [31:0] da,
                        input logic [3:0] dw, input logic [31:0] dd);
      @(negedge clk);
      mem_req = mr; mem_addr = ma; mem_wen = mw; mem_wdata = md;
      dbg_req = dr; dbg_addr = da; dbg_wen = dw; dbg_wdata = dd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // Both requesters read continuously; counter assumed 0 on entry, so dbg wins every 9th cycle
   task automatic contend(input int n);
      logic prev_m;
      logic prev_d;
      logic exp_d;
      prev_m = 1'b0;
      prev_d = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 32'h40, 4'h0, 32'h0, 1'b1, 32'h44, 4'h0, 32'h0);
         exp_d = ((i % 9) == 8);
         check("contend_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, exp_d});
         check("contend_mem_gnt", {31'd0, mem_gnt}, {31'd0, ~exp_d});
         check("contend_ram_addr", ram_addr, exp_d ? 32'h44 : 32'h40);
         if (i > 0) begin
            check("contend_mem_rvalid", {31'd0, mem_rvalid}, {31'd0, prev_m});
            check("contend_dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, prev_d});
            if (prev_d) check("contend_dbg_rdata", dbg_rdata, 32'h4444_4444);
         end
         prev_m = ~exp_d;
         prev_d = exp_d;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int a = 0; a < 64; a++) ram_mem[a] = 32'h0;
      ram_mem[32'h10 >> 2] = 32'hDEAD_BEEF;
      ram_mem[32'h20 >> 2] = 32'h2020_2020;
      ram_mem[32'h24 >> 2] = 32'h2424_2424;
      ram_mem[32'h30 >> 2] = 32'h1122_3344;
      ram_mem[32'h40 >> 2] = 32'h4040_4040;
      ram_mem[32'h44 >> 2] = 32'h4444_4444;

      // Reset with both requesters asking to write: nothing may leak out
      resetn = 1'b0;
      mem_req = 1'b1; mem_addr = 32'h8; mem_wen = 4'hF; mem_wdata = 32'hFFFF_FFFF;
      dbg_req = 1'b1; dbg_addr = 32'hC; dbg_wen = 4'hF; dbg_wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mem_gnt", {31'd0, mem_gnt}, 32'd0);
      check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      check("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
      check("rst_rvalid", {30'd0, mem_rvalid, dbg_rvalid}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      idle();

      // 1: lone MEM read of 0x10
      drive(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("t1_mem_gnt", {31'd0, mem_gnt}, 32'd1);
      check("t1_ram_addr", ram_addr, 32'h10);
      check("t1_ram_wen", {28'd0, ram_wen}, 32'd0);
      idle();
      check("t1_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
      check("t1_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
      check("t1_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      idle();
      check("t1_rvalid_drop", {31'd0, mem_rvalid}, 32'd0);

      // 2: continuous contention, two full starvation periods
      contend(18);
      idle();

      // Dropping dbg_req clears the counter: after 5 denials and a gap, a fresh 8 are needed
      contend(5);
      drive(1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 32'h44, 4'h0, 32'h0);
      check("gap_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      contend(9);
      idle();

      // 3: MEM read 0x20 then dbg read 0x24 on the next cycle
      drive(1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("t3_mem_gnt", {31'd0, mem_gnt}, 32'd1);
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h24, 4'h0, 32'h0);
      check("t3_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
      check("t3_ram_addr", ram_addr, 32'h24);
      check("t3_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
      check("t3_mem_rdata", mem_rdata, 32'h2020_2020);
      check("t3_dbg_rvalid_early", {31'd0, dbg_rvalid}, 32'd0);
      idle();
      check("t3_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
      check("t3_dbg_rdata", dbg_rdata, 32'h2424_2424);
      check("t3_mem_rvalid_off", {31'd0, mem_rvalid}, 32'd0);

      // 4: MEM byte store to 0x31 lane 2, then read back 0x30
      drive(1'b1, 32'h31, 4'b0100, 32'h00AA_0000, 1'b0, 32'h0, 4'h0, 32'h0);
      check("t4_ram_wen", {28'd0, ram_wen}, 32'h4);
      check("t4_ram_wdata", ram_wdata, 32'h00AA_0000);
      check("t4_ram_addr", ram_addr, 32'h31);
      drive(1'b1, 32'h30, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      check("t4_no_wr_rvalid", {30'd0, mem_rvalid, dbg_rvalid}, 32'd0);
      check("t4_ram_wen_off", {28'd0, ram_wen}, 32'd0);
      idle();
      check("t4_rd_rvalid", {31'd0, mem_rvalid}, 32'd1);
      check("t4_rd_rdata", mem_rdata, 32'h11AA_3344);

      // MEM read + dbg write to the same address: MEM served, dbg write held off
      drive(1'b1, 32'h30, 4'h0, 32'h0, 1'b1, 32'h30, 4'hF, 32'h5555_5555);
      check("coll_mem_gnt", {31'd0, mem_gnt}, 32'd1);
      check("coll_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
      check("coll_ram_wen", {28'd0, ram_wen}, 32'd0);

      // 6: dbg writes alone for 3 cycles (the first also returns the MEM read above)
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h30 + 32'(4 * i), 4'hF, 32'h5555_5555);
         check("t6_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
         check("t6_ram_wen", {28'd0, ram_wen}, 32'hF);
         check("t6_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
         if (i == 0) check("coll_mem_rdata", mem_rdata, 32'h11AA_3344);
         else        check("t6_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
      end
      idle();
      check("t6_no_rvalid", {30'd0, mem_rvalid, dbg_rvalid}, 32'd0);
      // dbg then idle for a cycle: counter must not have moved, full 8 denials required
      contend(9);
      idle();

      // 5: build up starvation count, end on a MEM read grant, reset right at the edge
      contend(4);
      @(posedge clk);
      resetn = 1'b0;
      mem_wen = 4'hF;
      dbg_wen = 4'hF;
      #1;
      check("t5_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
      check("t5_gnt", {30'd0, mem_gnt, dbg_gnt}, 32'd0);
      check("t5_ram_wen", {28'd0, ram_wen}, 32'd0);
      @(negedge clk);
      #1;
      check("t5_hold_rvalid", {30'd0, mem_rvalid, dbg_rvalid}, 32'd0);
      check("t5_hold_wen", {28'd0, ram_wen}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      mem_req = 1'b0;
      dbg_req = 1'b0;
      idle();
      check("t5_post_rvalid", {30'd0, mem_rvalid, dbg_rvalid}, 32'd0);
      // counter must restart from 0 after reset
      contend(9);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
